// File: rtl/puf_host_cmd.sv
`default_nettype none
// ============================================================================
// Module   : puf_host_cmd
// Purpose  : Host command front end for the DAPUF controller. Assembles a
//            CRP challenge or TRNG seed from host bytes, starts the
//            controller, waits for done (with timeout) and returns a
//            9-byte status+data frame on a valid/ready byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module puf_host_cmd #(
  parameter int TIMEOUT_CYC = 200000,
  parameter int TO_W        = 18
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        en_pulse,
  output logic        en_pulse_trng,
  output logic        trng_trig,
  output logic [63:0] C_in,
  output logic [47:0] C_in_trng,
  input  logic        done,
  input  logic [63:0] resp_out,
  input  logic [63:0] trng_out,
  input  logic [6:0]  ones_count,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  localparam logic [7:0]      OP_CRP  = 8'hA1;
  localparam logic [7:0]      OP_TRNG = 8'hA2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic            mode_q, mode_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [63:0]     c_in_q, c_in_d;
  logic [47:0]     c_in_trng_q, c_in_trng_d;
  logic            trng_trig_q, trng_trig_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [63:0]     data_sr_q, data_sr_d;
  logic [7:0]      status_q, status_d;
  logic            err_q, err_d;
  logic [3:0]      tx_idx_q, tx_idx_d;

  logic is_op, last_byte, to_hit, tx_fire;

  assign is_op     = (rx_data == OP_CRP) || (rx_data == OP_TRNG);
  assign last_byte = (cnt_q == (mode_q ? 3'd5 : 3'd7));
  assign to_hit    = (to_cnt_q == TO_LAST);
  assign tx_fire   = (state_q == S_TX) && tx_ready;

  // State register and all datapath flops; rst clears everything at once
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      c_in_q      <= '0;
      c_in_trng_q <= '0;
      trng_trig_q <= 1'b0;
      to_cnt_q    <= '0;
      data_sr_q   <= '0;
      status_q    <= '0;
      err_q       <= 1'b0;
      tx_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      c_in_q      <= c_in_d;
      c_in_trng_q <= c_in_trng_d;
      trng_trig_q <= trng_trig_d;
      to_cnt_q    <= to_cnt_d;
      data_sr_q   <= data_sr_d;
      status_q    <= status_d;
      err_q       <= err_d;
      tx_idx_q    <= tx_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_valid && is_op) state_d = S_LOAD;
      S_LOAD:  if (rx_valid && last_byte) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done || to_hit) state_d = S_TX;
      S_TX:    if (tx_fire && (tx_idx_q == 4'd8)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: challenge loading, timeout count, result capture
  always_comb begin
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    c_in_d      = c_in_q;
    c_in_trng_d = c_in_trng_q;
    trng_trig_d = trng_trig_q;
    to_cnt_d    = to_cnt_q;
    data_sr_d   = data_sr_q;
    status_d    = status_q;
    err_d       = err_q;
    tx_idx_d    = tx_idx_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && is_op) begin
          mode_d = (rx_data == OP_TRNG);
          err_d  = 1'b0;
          cnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          for (int k = 0; k < 8; k++) begin
            if (!mode_q && (cnt_q == 3'(k))) c_in_d[8*k +: 8] = rx_data;
          end
          for (int k = 0; k < 6; k++) begin
            if (mode_q && (cnt_q == 3'(k))) c_in_trng_d[8*k +: 8] = rx_data;
          end
          cnt_d = cnt_q + 3'd1;
          if (last_byte) begin
            // Counter is zero during START, so it equals TIMEOUT_CYC-1
            // exactly TIMEOUT_CYC-1 cycles after START.
            to_cnt_d = '0;
            if (mode_q) trng_trig_d = 1'b1;
          end
        end
      end
      S_START: to_cnt_d = to_cnt_q + TO_W'(1);
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        tx_idx_d = '0;
        if (done) begin
          data_sr_d = mode_q ? trng_out : resp_out;
          status_d  = {1'b0, ones_count};
        end else if (to_hit) begin
          data_sr_d = '0;
          status_d  = 8'h80;
          err_d     = 1'b1;
        end
      end
      S_TX: begin
        if (tx_fire) begin
          tx_idx_d = tx_idx_q + 4'd1;
          if (tx_idx_q == 4'd8) trng_trig_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; tx_data only changes when the index moves
  always_comb begin
    en_pulse      = (state_q == S_START) && !mode_q;
    en_pulse_trng = (state_q == S_START) && mode_q;
    busy          = (state_q != S_IDLE);
    tx_valid      = (state_q == S_TX);
    tx_data       = 8'h00;
    if (state_q == S_TX) begin
      if (tx_idx_q == 4'd0) tx_data = status_q;
      for (int k = 1; k < 9; k++) begin
        if (tx_idx_q == 4'(k)) tx_data = data_sr_q[8*(k-1) +: 8];
      end
    end
  end

  assign trng_trig = trng_trig_q;
  assign C_in      = c_in_q;
  assign C_in_trng = c_in_trng_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_host_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_host_cmd
// Purpose  : Directed self-checking bench for puf_host_cmd.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_host_cmd;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        en_pulse, en_pulse_trng, trng_trig;
  logic [63:0] C_in;
  logic [47:0] C_in_trng;
  logic        done = 1'b0;
  logic [63:0] resp_out = '0;
  logic [63:0] trng_out = '0;
  logic [6:0]  ones_count = '0;
  logic        busy, err;

  int n_cmp = 0;
  int n_err = 0;

  puf_host_cmd #(.TIMEOUT_CYC(50), .TO_W(8)) dut (
    .mclk(mclk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .en_pulse(en_pulse), .en_pulse_trng(en_pulse_trng), .trng_trig(trng_trig),
    .C_in(C_in), .C_in_trng(C_in_trng),
    .done(done), .resp_out(resp_out), .trng_out(trng_out), .ones_count(ones_count),
    .busy(busy), .err(err)
  );

  always #5 mclk = ~mclk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [63:0] pay, input int n);
    send(op);
    for (int k = 0; k < n; k++) send(pay[8*k +: 8]);
  endtask

  // Called in the START cycle; pulses done in cycle START+dly
  task automatic run_done(input int dly);
    for (int i = 1; i <= dly; i++) begin
      tick();
      if (i == 1) begin
        chk("pulse_one_cycle", {62'd0, en_pulse, en_pulse_trng}, 64'd0);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Receives one frame; f holds byte 0 in bits [71:64]
  task automatic rx_frame(input logic [71:0] f, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] prev = 8'h00;
    chk("tx_valid_start", {63'd0, tx_valid}, 64'd1);
    while (idx < 9 && cyc < 200) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk("tx_hold", {56'd0, tx_data}, {56'd0, prev});
      if (tx_valid && tx_ready) begin
        chk($sformatf("tx_byte%0d", idx), {56'd0, tx_data}, {56'd0, f[71-8*idx -: 8]});
        idx++;
      end
      stalled = tx_valid && !tx_ready;
      prev    = tx_data;
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    chk("frame_bytes", 64'(idx), 64'd9);
    if (!rnd) chk("frame_cycles", 64'(cyc), 64'd9);
    chk("idle_after_frame", {62'd0, busy, tx_valid}, 64'd0);
  endtask

  initial begin
    int i;
    // Reset state
    tick(); tick();
    chk("rst_ctrl", {57'd0, busy, err, tx_valid, en_pulse, en_pulse_trng, trng_trig, 1'b0}, 64'd0);
    chk("rst_txdata", {56'd0, tx_data}, 64'd0);
    chk("rst_cin", C_in, 64'd0);
    chk("rst_cin_trng", {16'd0, C_in_trng}, 64'd0);
    rst = 1'b0;
    tick();

    // Junk byte in IDLE
    send(8'h55);
    chk("junk_idle", {63'd0, busy}, 64'd0);

    // CRP round trip
    resp_out   = 64'hDEADBEEF_01234567;
    trng_out   = 64'h1111_2222_3333_4444;
    ones_count = 7'd33;
    send(8'hA1);
    chk("load_busy", {63'd0, busy}, 64'd1);
    for (int k = 2; k <= 8; k++) send(8'(k - 1));
    chk("crp_not_yet", {63'd0, en_pulse}, 64'd0);
    send(8'h08);
    chk("crp_en", {61'd0, en_pulse, en_pulse_trng, trng_trig}, 64'b100);
    chk("crp_cin", C_in, 64'h08070605_04030201);
    run_done(20);
    rx_frame(72'h21_67_45_23_01_EF_BE_AD_DE, 1'b0);
    chk("crp_err", {63'd0, err}, 64'd0);

    // TRNG round trip with backpressure
    trng_out   = 64'hFFFF0000_FFFF0000;
    ones_count = 7'd32;
    send_cmd(8'hA2, 64'h0000_AAAA_AAAA_AAAA, 6);
    chk("trng_en", {61'd0, en_pulse, en_pulse_trng, trng_trig}, 64'b011);
    chk("trng_cin", {16'd0, C_in_trng}, 64'h0000_AAAA_AAAA_AAAA);
    chk("trng_cin_crp_held", C_in, 64'h08070605_04030201);
    run_done(10);
    chk("trng_trig_tx", {63'd0, trng_trig}, 64'd1);
    rx_frame(72'h20_00_00_FF_FF_00_00_FF_FF, 1'b1);
    chk("trng_trig_idle", {63'd0, trng_trig}, 64'd0);

    // Timeout: tx_valid 50 cycles after START, zero frame, sticky err
    send_cmd(8'hA1, 64'h18171615_14131211, 8);
    chk("to_start", {63'd0, en_pulse}, 64'd1);
    i = 0;
    while (!tx_valid && i < 100) begin
      tick();
      i++;
    end
    chk("to_latency", 64'(i), 64'd50);
    chk("to_err", {63'd0, err}, 64'd1);
    rx_frame(72'h80_00_00_00_00_00_00_00_00, 1'b1);
    chk("to_err_sticky", {63'd0, err}, 64'd1);

    // Overlap: junk bytes during WAIT_DONE, done coincident with timeout
    resp_out   = 64'h0123456789ABCDEF;
    ones_count = 7'd5;
    send_cmd(8'hA1, 64'h2827262524232221, 8);
    chk("ovl_err_clear", {63'd0, err}, 64'd0);
    for (int k = 1; k <= 49; k++) begin
      if (k == 3 || k == 4) begin
        rx_data  = (k == 3) ? 8'hA2 : 8'h33;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
      tick();
    end
    rx_valid = 1'b0;
    chk("ovl_waiting", {62'd0, busy, tx_valid}, 64'b10);
    done = 1'b1;
    tick();
    done = 1'b0;
    rx_frame(72'h05_EF_CD_AB_89_67_45_23_01, 1'b0);
    chk("ovl_err", {63'd0, err}, 64'd0);
    chk("ovl_cin", C_in, 64'h2827262524232221);

    // Reset mid-LOAD
    send(8'hA1);
    send(8'h99);
    send(8'h98);
    rst = 1'b1;
    #1;
    chk("rst_load", {61'd0, busy, tx_valid, err}, 64'd0);
    chk("rst_load_cin", C_in, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-WAIT_DONE of a TRNG op
    send_cmd(8'hA2, 64'h0000_1234_5678_9ABC, 6);
    tick(); tick(); tick();
    chk("wait_trig", {63'd0, trng_trig}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_wait", {60'd0, busy, trng_trig, en_pulse_trng, tx_valid}, 64'd0);
    chk("rst_wait_cin", {16'd0, C_in_trng}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Normal A1 frame after reset
    resp_out   = 64'hA5A5A5A5_5A5A5A5A;
    ones_count = 7'd32;
    send_cmd(8'hA1, 64'h0102030405060708, 8);
    chk("post_rst_en", {63'd0, en_pulse}, 64'd1);
    run_done(3);
    rx_frame(72'h20_5A_5A_5A_5A_A5_A5_A5_A5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/puf_host_cmd.md
# puf_host_cmd

Host-side command front end for the DAPUF controller. It takes command bytes from the host byte link and assembles a 64-bit CRP challenge or a 48-bit TRNG seed. It then drives the controller's enable pulses and `trng_trig`, waits for `done`, captures the 64-bit result, and returns it to the host as a 9-byte status+data frame on a valid/ready byte stream. It sits between the host UART/byte link and the PUF controller, and is the only requester of PUF operations.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 200000: number of cycles to wait for `done` before aborting.
- `TO_W`, default 18: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- `mclk`, in, 1: system clock. Every register changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high; clock `mclk`.
- `rx_data`, in, 8: host command byte.
- `rx_valid`, in, 1: one-cycle strobe marking `rx_data` valid. No backpressure.
- `tx_data`, out, 8: response byte to the host.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: host accepts the byte. A byte transfers when `tx_valid` && `tx_ready`.
- `en_pulse`, out, 1: one-cycle CRP start to the controller.
- `en_pulse_trng`, out, 1: one-cycle TRNG start to the controller.
- `trng_trig`, out, 1: TRNG mode level to the controller.
- `C_in`, out, 64: CRP challenge.
- `C_in_trng`, out, 48: TRNG low challenge bits.
- `done`, in, 1: controller completion pulse.
- `resp_out`, in, 64: CRP response from the controller.
- `trng_out`, in, 64: TRNG output from the controller.
- `ones_count`, in, 7: ones count from the controller.
- `busy`, out, 1: high in every state except IDLE.
- `err`, out, 1: sticky timeout flag.

## Operation
States: IDLE, LOAD, START, WAIT_DONE, TX.
- **IDLE**
  - An accepted `rx_valid` byte of 0xA1 selects CRP: mode=0, need=8.
  - 0xA2 selects TRNG: mode=1, need=6.
  - Either opcode clears `err`, clears the byte counter, and moves to LOAD.
  - Any other byte is dropped and the state stays IDLE.
- **LOAD**
  - Each `rx_valid` byte is written LSB-first: byte k goes to bits [8k+7:8k] of `C_in` (CRP) or `C_in_trng` (TRNG).
  - After byte `need`-1 is accepted, go to START.
  - No timeout in LOAD. The host must complete the frame; only `rst` aborts.
- **START** (exactly 1 cycle)
  - `en_pulse` = !mode and `en_pulse_trng` = mode.
  - `trng_trig` is registered high from the START entry edge when mode=1.
  - Clear the timeout counter, then go to WAIT_DONE.
- **WAIT_DONE**
  - The counter increments every cycle.
  - On `done`, capture `data_sr` = mode ? `trng_out` : `resp_out`, and `status` = {1'b0, `ones_count`}.
  - On counter == TIMEOUT_CYC-1 with no `done`, set `data_sr` = 0, `status` = 0x80, and `err` = 1.
  - If `done` and the timeout occur in the same cycle, `done` wins.
  - Either exit goes to TX with byte index 0.
- **TX**
  - Byte 0 is `status`; bytes 1..8 are `data_sr[7:0]` through `data_sr[63:56]`.
  - The byte index advances only on a transfer.
  - After byte 8 transfers, go to IDLE.
- `trng_trig` falls on the edge entering IDLE. It stays high throughout WAIT_DONE and TX of a TRNG operation.
- `rx_valid` bytes received in START, WAIT_DONE and TX are dropped.
- `C_in` and `C_in_trng` hold their values until overwritten by the next LOAD of the same mode.

## Timing
- **Reset values:** every output is 0, including `C_in`, `C_in_trng`, `err`, `tx_data` and the state (IDLE).
  - `rst` asserted mid-operation returns to IDLE immediately.
  - `trng_trig` and any enable pulse drop asynchronously.
- **Start latency:** the START cycle is the cycle after the edge that accepted the last challenge byte. `en_pulse`/`en_pulse_trng` is high for exactly that one cycle.
- **Challenge stability:** `C_in`/`C_in_trng` are stable from the START cycle through IDLE entry.
- **TX start:** `tx_valid` rises in the cycle after the `done` (or timeout) edge and stays high until byte 8 transfers.
  - `tx_data` must not change while `tx_valid` && !`tx_ready`.
  - With `tx_ready` held high, the frame takes exactly 9 cycles.
- **Return to IDLE:** `busy` falls on the edge after byte 8 transfers. A new opcode is accepted in the first IDLE cycle.
- **Timeout arithmetic:** the counter is TO_W bits, unsigned. It reaches TIMEOUT_CYC-1 at most TIMEOUT_CYC cycles after START, so it never wraps.

## Test plan
- **CRP round trip:**
  - Stimulus: send A1, 0x01..0x08; model returns `done` 20 cycles after `en_pulse` with `resp_out`=0xDEADBEEF_01234567 and `ones_count`=33; `tx_ready`=1.
  - Required: `C_in`=0x08070605_04030201; one `en_pulse` cycle; `trng_trig`=0; frame 0x21,67,45,23,01,EF,BE,AD,DE.
- **TRNG round trip:**
  - Stimulus: send A2, 0xAA×6; `done` arrives with `trng_out`=0xFFFF0000_FFFF0000 and `ones_count`=32.
  - Required: `C_in_trng`=0xAAAAAAAAAAAA; `en_pulse_trng` one cycle; `trng_trig` high from START until IDLE; status byte 0x20.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYC`=50, no `done`.
  - Required: `tx_valid` rises 50 cycles after START; frame 0x80 followed by eight 0x00; `err`=1 until the next A1/A2.
- **Backpressure:**
  - Stimulus: toggle `tx_ready` pseudo-randomly.
  - Required: `tx_data` is held stable while stalled; exactly 9 transfers in order; no dropped or duplicated bytes.
- **Junk and overlap:**
  - Stimulus: 0x55 in IDLE; extra bytes during WAIT_DONE; `done` and timeout in the same cycle.
  - Required: state stays IDLE on 0x55; the extra bytes are ignored; the captured data is used with status bit7=0.
- **Reset mid-LOAD and mid-WAIT_DONE:**
  - Stimulus: assert `rst` partway through LOAD, then separately partway through WAIT_DONE.
  - Required: all outputs 0 immediately; the next A1 frame completes normally.
